// File: rtl/alu_unit_if.sv
// Operand/result bundle for alu_unit. Build with ALU_FLAGS_EN defined to add the
// carry/overflow/negative status outputs.
interface alu_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       f;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             zero;
`ifdef ALU_FLAGS_EN
  logic             carry;
  logic             overflow;
  logic             negative;

  modport master (
    output in_valid, a, b, f,
    input  out_valid, y, zero, carry, overflow, negative
  );
  modport slave (
    input  in_valid, a, b, f,
    output out_valid, y, zero, carry, overflow, negative
  );
`else
  modport master (
    output in_valid, a, b, f,
    input  out_valid, y, zero
  );
  modport slave (
    input  in_valid, a, b, f,
    output out_valid, y, zero
  );
`endif
endinterface

// File: rtl/alu_unit.sv
// Registered integer ALU (AND/OR/ADD/SUB/SLT/inverted-B logic) with a zero flag.
// Defining ALU_FLAGS_EN adds registered carry/overflow/negative outputs.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_unit_if.slave  bus
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic             lt;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             zero_d;
  logic             zero_q;
  logic             out_valid_q;

`ifdef ALU_FLAGS_EN
  logic             carry_out;
  logic             carry_d;
  logic             carry_q;
  logic             overflow_d;
  logic             overflow_q;
  logic             negative_q;
`endif

  // ADD and SUB share one adder; f[2] both inverts B and supplies the +1.
  always_comb begin
    bb = bus.f[2] ? ~bus.b : bus.b;
`ifdef ALU_FLAGS_EN
    {carry_out, sum} = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, bus.f[2]};
`else
    sum = bus.a + bb + {{(WIDTH-1){1'b0}}, bus.f[2]};
`endif
    add_ovf = (bus.a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    // Sign of the difference corrected for overflow gives the true signed compare.
    lt = sum[WIDTH-1] ^ add_ovf;
  end

  always_comb begin
    y_d = '0;
    unique case (bus.f[1:0])
      2'b00: y_d = bus.a & bb;
      2'b01: y_d = bus.a | bb;
      2'b10: y_d = sum;
      2'b11: y_d = bus.f[2] ? {{(WIDTH-1){1'b0}}, lt} : '0;
      default: y_d = '0;
    endcase
    zero_d = (y_d == '0);
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    carry_d    = (bus.f[1:0] == 2'b10) ? carry_out : 1'b0;
    overflow_d = (bus.f[1:0] == 2'b10) ? add_ovf   : 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q        <= y_d;
        zero_q     <= zero_d;
`ifdef ALU_FLAGS_EN
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        negative_q <= y_d[WIDTH-1];
`endif
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
`ifdef ALU_FLAGS_EN
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.negative  = negative_q;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed vectors push expected results, a
// monitor pops and compares whenever out_valid is seen.
module tb_alu_unit;

  logic clk;
  logic rst_n;
  logic done;

  alu_unit_if #(.WIDTH(32)) bus ();

  alu_unit #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] y;
    logic        carry;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: all comparisons live here.
  logic [31:0] hold_y;
  logic        hold_zero;
  logic        hold_carry;
  logic        hold_ovf;
  logic        drained;
  exp_t        e;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk("rst_y", bus.y, 32'h0);
      chk("rst_zero", {31'h0, bus.zero}, 32'h1);
      chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
`ifdef ALU_FLAGS_EN
      chk("rst_flags", {29'h0, bus.carry, bus.overflow, bus.negative}, 32'h0);
`endif
      hold_y     = 32'h0;
      hold_zero  = 1'b1;
      hold_carry = 1'b0;
      hold_ovf   = 1'b0;
    end else if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", {31'h0, bus.out_valid}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("y", bus.y, e.y);
        chk("zero", {31'h0, bus.zero}, {31'h0, (e.y == 32'h0)});
`ifdef ALU_FLAGS_EN
        chk("carry", {31'h0, bus.carry}, {31'h0, e.carry});
        chk("overflow", {31'h0, bus.overflow}, {31'h0, e.ovf});
        chk("negative", {31'h0, bus.negative}, {31'h0, e.y[31]});
`endif
        hold_y     = e.y;
        hold_zero  = (e.y == 32'h0);
        hold_carry = e.carry;
        hold_ovf   = e.ovf;
      end
    end else begin
      chk("hold_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("hold_y", bus.y, hold_y);
      chk("hold_zero", {31'h0, bus.zero}, {31'h0, hold_zero});
`ifdef ALU_FLAGS_EN
      chk("hold_flags", {29'h0, bus.carry, bus.overflow, bus.negative},
          {29'h0, hold_carry, hold_ovf, hold_y[31]});
`endif
      if (done && !drained) begin
        drained = 1'b1;
        chk("scoreboard_drained", sb_q.size(), 32'h0);
      end
    end
  end

  task automatic issue(input logic [2:0] fn, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ey, input logic ec, input logic eo);
    exp_t ex;
    bus.in_valid = 1'b1;
    bus.f        = fn;
    bus.a        = av;
    bus.b        = bv;
    ex.y         = ey;
    ex.carry     = ec;
    ex.ovf       = eo;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.f        = 3'($urandom_range(0, 7));
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.f = 3'($urandom_range(0, 7));
      bus.a = $urandom;
      bus.b = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done         = 1'b0;
    drained      = 1'b0;
    hold_y       = 32'h0;
    hold_zero    = 1'b1;
    hold_carry   = 1'b0;
    hold_ovf     = 1'b0;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.f        = 3'b000;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    issue(3'b010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0);
    issue(3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(3'b000, 32'h5, 32'h3, 32'h1, 1'b0, 1'b0);
    issue(3'b001, 32'h5, 32'h3, 32'h7, 1'b0, 1'b0);
    issue(3'b100, 32'h5, 32'h3, 32'h4, 1'b0, 1'b0);
    issue(3'b101, 32'h5, 32'h3, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(3'b110, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(3'b110, 32'h7, 32'h7, 32'h0, 1'b1, 1'b0);
    issue(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    issue(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
    issue(3'b111, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1'b0);
    issue(3'b111, 32'h5, 32'h7, 32'h1, 1'b0, 1'b0);
    issue(3'b011, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    issue(3'b010, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0);
    idle(4);
    issue(3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    idle(1);
    issue(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);

    // Reset mid-stream while a fresh operation is presented: it must be dropped.
    @(negedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.f        = 3'b010;
    bus.a        = 32'h1;
    bus.b        = 32'h2;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    idle(2);

    issue(3'b001, 32'hA000_0000, 32'h0000_000A, 32'hA000_000A, 1'b0, 1'b0);
    issue(3'b110, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    done = 1'b1;
    idle(4);
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
